// File: rtl/alu_serial_arbiter_if.sv
// Requester/response bus between host agents (master) and alu_serial_arbiter (slave).
interface alu_serial_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [3*N_REQ-1:0]  req_op;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_c;
    logic [7:0]          rsp_status;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_c, rsp_status, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_c, rsp_status, rsp_err
    );
endinterface

// File: rtl/alu_serial_arbiter.sv
// Round-robin front end sharing one serial ALU (11-bit sin/sout packets) among N_REQ requesters.
// Optional macro RSP_CRC_CHECK_EN: verify crc3 carried in the response ctl byte.
module alu_serial_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    alu_serial_arbiter_if.slave bus,
    output logic                sin,
    input  logic                sout
);
    // state | meaning
    // IDLE  | arbitrate among req_valid, sin idle high
    // SEND  | shift the 99-bit command frame onto sin
    // WAIT  | wait for the first response start bit, timeout armed
    // RECV  | deserialize response packets, gap timeout armed between packets
    // DONE  | one-cycle rsp_valid pulse to the granted requester
    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

    localparam int PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW         = $clog2(TIMEOUT + 1);
    localparam int FRAME_BITS = 99;

    function automatic logic [3:0] crc4_calc(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

`ifdef RSP_CRC_CHECK_EN
    function automatic logic [2:0] crc3_calc(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction
`endif

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;
    logic [6:0]    bit_cnt;
    logic [TW-1:0] tmr;
    logic          in_pkt;
    logic [3:0]    rx_cnt;
    logic [8:0]    rx_sh;
    logic [2:0]    pkt_idx;
    logic [31:0]   c_acc;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;

    always_comb begin
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!gnt_any && bus.req_valid[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    // frame[k] is the k-th bit on the line: 8 data packets (B then A, MSB byte first) and one ctl packet
    logic [3:0]            crc4;
    logic [71:0]           tx_bytes;
    logic [FRAME_BITS-1:0] frame;

    always_comb begin
        crc4     = crc4_calc({b_q, a_q, 1'b1, op_q});
        tx_bytes = {b_q, a_q, 1'b0, op_q, crc4};
        frame    = '1;
        for (int p = 0; p < 9; p++) begin
            frame[11*p]     = 1'b0;
            frame[11*p + 1] = (p == 8);
            for (int j = 0; j < 8; j++)
                frame[11*p + 2 + j] = tx_bytes[71 - 8*p - j];
        end
    end

    task automatic post_rsp(input logic err, input logic [7:0] status, input logic [31:0] c);
        bus.rsp_err        <= err;
        bus.rsp_status     <= status;
        bus.rsp_c          <= c;
        bus.rsp_valid[g_q] <= 1'b1;
        state              <= DONE;
    endtask

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sin            <= 1'b1;
            ptr            <= PW'(N_REQ - 1);
            g_q            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            bit_cnt        <= '0;
            tmr            <= '0;
            in_pkt         <= 1'b0;
            rx_cnt         <= '0;
            rx_sh          <= '0;
            pkt_idx        <= '0;
            c_acc          <= '0;
            bus.req_ready  <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_c      <= '0;
            bus.rsp_status <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                    sin <= 1'b1;
                    if (gnt_any) begin
                        a_q                    <= bus.req_a[32*gnt_idx +: 32];
                        b_q                    <= bus.req_b[32*gnt_idx +: 32];
                        op_q                   <= bus.req_op[3*gnt_idx +: 3];
                        g_q                    <= gnt_idx;
                        ptr                    <= gnt_idx;
                        bus.req_ready[gnt_idx] <= 1'b1;
                        // the first start bit leaves with the grant, so SEND spans exactly 99 cycles
                        sin                    <= 1'b0;
                        bit_cnt                <= 7'd1;
                        state                  <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt == 7'(FRAME_BITS)) begin
                        sin   <= 1'b1;
                        tmr   <= TW'(TIMEOUT);
                        state <= WAIT;
                    end else begin
                        sin     <= frame[bit_cnt];
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                WAIT: begin
                    if (!sout) begin
                        in_pkt  <= 1'b1;
                        rx_cnt  <= 4'd1;
                        pkt_idx <= '0;
                        state   <= RECV;
                    end else if (tmr == TW'(1)) begin
                        post_rsp(1'b1, 8'hFF, 32'h0);
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                RECV: begin
                    if (in_pkt) begin
                        if (rx_cnt == 4'd10) begin
                            in_pkt  <= 1'b0;
                            tmr     <= TW'(TIMEOUT);
                            pkt_idx <= pkt_idx + 3'd1;
                            if (!sout) begin
                                post_rsp(1'b1, 8'hFE, 32'h0);
                            end else if (rx_sh[8]) begin
                                if (pkt_idx == 3'd0) begin
                                    post_rsp(1'b1, rx_sh[7:0], 32'h0);
                                end else if (pkt_idx == 3'd4) begin
`ifdef RSP_CRC_CHECK_EN
                                    if (crc3_calc({c_acc, 1'b0, rx_sh[6:3]}) != rx_sh[2:0])
                                        post_rsp(1'b1, 8'hFD, c_acc);
                                    else
                                        post_rsp(1'b0, rx_sh[7:0], c_acc);
`else
                                    post_rsp(1'b0, rx_sh[7:0], c_acc);
`endif
                                end else begin
                                    post_rsp(1'b1, 8'hFE, 32'h0);
                                end
                            end else if (pkt_idx == 3'd4) begin
                                post_rsp(1'b1, 8'hFE, 32'h0);
                            end else begin
                                c_acc <= {c_acc[23:0], rx_sh[7:0]};
                            end
                        end else begin
                            rx_sh  <= {rx_sh[7:0], sout};
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end else if (!sout) begin
                        in_pkt <= 1'b1;
                        rx_cnt <= 4'd1;
                    end else if (tmr == TW'(1)) begin
                        post_rsp(1'b1, 8'hFF, 32'h0);
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                DONE: begin
                    sin   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
